// File: rtl/matrix_row_packer.sv
`default_nettype none
// matrix_row_packer: packs 6-bit generator rows into three 32-bit words for sequential_sender.
// Rows are assembled in buffer A and handed to holding register H, so the next matrix can be
// assembled while the sender drains. Optional macro PACKER_TAG_EN puts tag k in bits [31:30] of word k.
module matrix_row_packer #(
  parameter int ROW_W    = 6,
  parameter int MAX_ROWS = 14,
  parameter int HOLDOFF  = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic [5:0]       ROWS,
  input  logic             row_valid,
  input  logic [ROW_W-1:0] row_data,
  output logic             row_ready,
  input  logic             gen_done,
  input  logic             snd_idle,
  output logic             load,
  output logic [31:0]      data_out_0,
  output logic [31:0]      data_out_1,
  output logic [31:0]      data_out_2,
  output logic             generation_done
);

  localparam int              HC_W       = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST  = HC_W'(HOLDOFF - 1);
  localparam logic [5:0]      MAX_ROWS_6 = 6'(MAX_ROWS);

  typedef enum logic [2:0] {
    S_EMPTY   = 3'd0,
    S_ARM     = 3'd1,
    S_LOAD    = 3'd2,
    S_HOLDOFF = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       row_cnt;
  logic [3:0]       rows_lat;
  logic [3:0]       rows_live;
  logic [3:0]       rows_cur;
  logic             a_complete;
  logic             ready_en;
  logic [ROW_W-1:0] a_rows [MAX_ROWS];
  logic [31:0]      a_word0, a_word1, a_word2;
  logic [31:0]      h_word0, h_word1, h_word2;
  logic [HC_W-1:0]  hold_cnt;
  logic             accept, last_row, h_full, h_release, transfer, flush, done_cond;

  always_comb begin
    rows_live = ROWS[3:0];
    if (ROWS == 6'd0)
      rows_live = 4'd1;
    else if (ROWS > MAX_ROWS_6)
      rows_live = MAX_ROWS_6[3:0];
  end

  // The row count only takes effect on a matrix's first row; later rows use the latched value.
  assign rows_cur  = (row_cnt == 4'd0) ? rows_live : rows_lat;

  assign h_full    = (state != S_EMPTY);
  assign row_ready = ready_en & clk_en & ~(a_complete & h_full) & ~generation_done;
  assign accept    = row_valid & row_ready;
  assign last_row  = accept & (row_cnt == (rows_cur - 4'd1));
  assign h_release = (state == S_DRAIN) & snd_idle;
  assign transfer  = a_complete & (~h_full | h_release);
  assign flush     = gen_done & ~accept & ~a_complete & (row_cnt != 4'd0);
  assign done_cond = gen_done & ~accept & ~a_complete & (row_cnt == 4'd0) & ~h_full;

  assign load       = (state == S_LOAD) & ~generation_done;
  assign data_out_0 = h_word0;
  assign data_out_1 = h_word1;
  assign data_out_2 = h_word2;

  // Rows 0-4 -> word0, 5-8 -> word1, 9-13 -> word2, LSB-first in 6-bit slots.
  always_comb begin
    a_word0 = '0;
    a_word1 = '0;
    a_word2 = '0;
    for (int r = 0; r < MAX_ROWS; r++) begin
      if (r < 5)
        a_word0[ROW_W*r +: ROW_W] = a_rows[r];
      else if (r < 9)
        a_word1[ROW_W*(r-5) +: ROW_W] = a_rows[r];
      else
        a_word2[ROW_W*(r-9) +: ROW_W] = a_rows[r];
    end
`ifdef PACKER_TAG_EN
    a_word1[31:30] = 2'b01;
    a_word2[31:30] = 2'b10;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_cnt    <= 4'd0;
      rows_lat   <= 4'd1;
      a_complete <= 1'b0;
      for (int r = 0; r < MAX_ROWS; r++)
        a_rows[r] <= '0;
    end else begin
      if (transfer) begin
        for (int r = 0; r < MAX_ROWS; r++)
          a_rows[r] <= '0;
      end
      // A row accepted in the transfer cycle lands in the freshly cleared buffer.
      if (accept) begin
        a_rows[row_cnt] <= row_data;
        if (row_cnt == 4'd0)
          rows_lat <= rows_live;
        row_cnt <= last_row ? 4'd0 : (row_cnt + 4'd1);
      end else if (flush) begin
        row_cnt <= 4'd0;
      end
      a_complete <= last_row | flush | (a_complete & ~transfer);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_word0 <= '0;
      h_word1 <= '0;
      h_word2 <= '0;
    end else if (transfer) begin
      h_word0 <= a_word0;
      h_word1 <= a_word1;
      h_word2 <= a_word2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_EMPTY;
      hold_cnt        <= '0;
      ready_en        <= 1'b0;
      generation_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= (state == S_HOLDOFF) ? (hold_cnt + HC_W'(1)) : '0;
      ready_en <= 1'b1;
      if (done_cond)
        generation_done <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY:   if (transfer) state_nxt = S_ARM;
      S_ARM:     if (snd_idle & ~generation_done) state_nxt = S_LOAD;
      S_LOAD:    state_nxt = S_HOLDOFF;
      // The sender's idle flag lags the load pulse, so it is ignored for a few cycles.
      S_HOLDOFF: if (hold_cnt == HOLD_LAST) state_nxt = S_DRAIN;
      S_DRAIN:   if (snd_idle) state_nxt = transfer ? S_ARM : S_EMPTY;
      default:   state_nxt = S_EMPTY;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_row_packer.sv
`default_nettype none
// tb_matrix_row_packer: randomized self-checking bench; expected words come from a row-list model.
module tb_matrix_row_packer;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        clk_en    = 1'b1;
  logic [5:0]  ROWS      = 6'd1;
  logic        row_valid = 1'b0;
  logic [5:0]  row_data  = 6'd0;
  logic        row_ready;
  logic        gen_done  = 1'b0;
  logic        snd_idle  = 1'b1;
  logic        load;
  logic [31:0] data_out_0, data_out_1, data_out_2;
  logic        generation_done;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_acc_cyc = 0;
  logic [95:0] obs_q[$];
  int          load_cyc_q[$];

`ifdef PACKER_TAG_EN
  localparam logic [31:0] TAG1 = 32'h4000_0000;
  localparam logic [31:0] TAG2 = 32'h8000_0000;
`else
  localparam logic [31:0] TAG1 = 32'h0;
  localparam logic [31:0] TAG2 = 32'h0;
`endif

  matrix_row_packer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .clk_en          (clk_en),
    .ROWS            (ROWS),
    .row_valid       (row_valid),
    .row_data        (row_data),
    .row_ready       (row_ready),
    .gen_done        (gen_done),
    .snd_idle        (snd_idle),
    .load            (load),
    .data_out_0      (data_out_0),
    .data_out_1      (data_out_1),
    .data_out_2      (data_out_2),
    .generation_done (generation_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (load) begin
      obs_q.push_back({data_out_2, data_out_1, data_out_0});
      load_cyc_q.push_back(cyc);
    end
  end

  function automatic int clamp_rows(input int r);
    if (r == 0) return 1;
    if (r > 14) return 14;
    return r;
  endfunction

  // Row i goes to word 0/1/2 at slot i, i-5, i-9 respectively.
  function automatic logic [95:0] model_words(input logic [83:0] rv, input int n);
    logic [31:0] w [3];
    int wi, slot;
    w[0] = 32'h0; w[1] = 32'h0; w[2] = 32'h0;
    for (int i = 0; i < n; i++) begin
      if (i < 5)      begin wi = 0; slot = i;     end
      else if (i < 9) begin wi = 1; slot = i - 5; end
      else            begin wi = 2; slot = i - 9; end
      w[wi] = w[wi] | (32'(rv[6*i +: 6]) << (6 * slot));
    end
    w[1] = w[1] | TAG1;
    w[2] = w[2] | TAG2;
    return {w[2], w[1], w[0]};
  endfunction

  task automatic push_row(input logic [5:0] d);
    int g;
    g = 0;
    @(posedge clk); #1;
    row_valid = 1'b1;
    row_data  = d;
    @(negedge clk);
    while (!row_ready && g < 300) begin @(negedge clk); g++; end
    if (g >= 300) begin
      checks++; failures++;
      $display("FAIL push_row_timeout: row_ready=%0b after %0d cycles, required 1", row_ready, g);
    end
    @(posedge clk); #1;
    last_acc_cyc = cyc;
    row_valid = 1'b0;
    row_data  = 6'($urandom);
  endtask

  task automatic wait_loads(input int n, input int budget, output bit ok);
    int g;
    g = 0;
    while (obs_q.size() < n && g < budget) begin @(negedge clk); g++; end
    ok = (obs_q.size() >= n);
  endtask

  task automatic run_matrix(input int rows_val, input int rows_mid, input logic [83:0] rv,
                            output logic [95:0] obs, output int lat, output bit ok);
    int n;
    n = clamp_rows(rows_val);
    obs_q.delete(); load_cyc_q.delete();
    ROWS = 6'(rows_val);
    for (int i = 0; i < n; i++) begin
      push_row(rv[6*i +: 6]);
      if (i == 0) ROWS = 6'(rows_mid);
    end
    wait_loads(1, 40, ok);
    obs = ok ? obs_q[0] : 96'h0;
    lat = ok ? (load_cyc_q[0] - last_acc_cyc) : -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (row_ready !== 1'b0) begin failures++; $display("FAIL reset_row_ready: got %0b want 0", row_ready); end
    checks++; if (load !== 1'b0) begin failures++; $display("FAIL reset_load: got %0b want 0", load); end
    checks++; if ({data_out_2, data_out_1, data_out_0} !== 96'h0) begin failures++;
      $display("FAIL reset_data: got %h want 0", {data_out_2, data_out_1, data_out_0}); end
    checks++; if (generation_done !== 1'b0) begin failures++; $display("FAIL reset_gen_done: got %0b want 0", generation_done); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (row_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %0b want 1", row_ready); end
  endtask

  task automatic test_packing();
    logic [83:0] rv;
    logic [95:0] obs, exp;
    int lat, rn, rm;
    bit ok;
    for (int it = 0; it < 10; it++) begin
      rv = 84'h0;
      if (it == 0) begin
        rn = 5;
        for (int i = 0; i < 5; i++) rv[6*i +: 6] = 6'(i + 1);
        exp = {TAG2, TAG1, 32'h0510_3081};
      end else if (it == 1) begin
        rn = 14;
        rv = {84{1'b1}};
        exp = {32'h3FFF_FFFF | TAG2, 32'h00FF_FFFF | TAG1, 32'h3FFF_FFFF};
      end else begin
        rn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(1, 14));
        for (int i = 0; i < 14; i++) rv[6*i +: 6] = 6'($urandom);
        exp = model_words(rv, clamp_rows(rn));
      end
      rm = int'($urandom_range(0, 63));
      run_matrix(rn, rm, rv, obs, lat, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL pack_timeout[%0d]: no load pulse, required one", it); end
      else if (obs !== exp) begin failures++; $display("FAIL pack_words[%0d] ROWS=%0d: got %h want %h", it, rn, obs, exp); end
      checks++;
      if (lat !== 2) begin failures++; $display("FAIL pack_latency[%0d]: got %0d want 2", it, lat); end
      checks++;
      if ({data_out_2, data_out_1, data_out_0} !== exp) begin failures++;
        $display("FAIL pack_hold[%0d]: got %h want %h", it, {data_out_2, data_out_1, data_out_0}, exp); end
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [83:0] rv1, rv2;
    bit ok;
    rv1 = 84'h0; rv2 = 84'h0;
    for (int i = 0; i < 3; i++) begin rv1[6*i +: 6] = 6'($urandom); rv2[6*i +: 6] = 6'($urandom); end
    obs_q.delete(); load_cyc_q.delete();
    snd_idle = 1'b0;
    ROWS = 6'd3;
    for (int i = 0; i < 3; i++) push_row(rv1[6*i +: 6]);
    for (int i = 0; i < 3; i++) push_row(rv2[6*i +: 6]);
    repeat (2) @(negedge clk);
    checks++; if (row_ready !== 1'b0) begin failures++; $display("FAIL b2b_backpressure: row_ready=%0b want 0", row_ready); end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL b2b_early_load: loads=%0d want 0", obs_q.size()); end
    @(posedge clk); #1;
    snd_idle = 1'b1;
    wait_loads(2, 60, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_timeout: loads=%0d want 2", obs_q.size()); end
    else begin
      if (obs_q[0] !== model_words(rv1, 3)) begin failures++;
        $display("FAIL b2b_first: got %h want %h", obs_q[0], model_words(rv1, 3)); end
      checks++;
      if (obs_q[1] !== model_words(rv2, 3)) begin failures++;
        $display("FAIL b2b_second: got %h want %h", obs_q[1], model_words(rv2, 3)); end
      checks++;
      if (load_cyc_q[1] - load_cyc_q[0] < 5) begin failures++;
        $display("FAIL b2b_gap: got %0d cycles want >= 5", load_cyc_q[1] - load_cyc_q[0]); end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_clk_en_stall();
    logic [83:0] rv;
    int stall_ready;
    bit ok;
    rv = 84'h0;
    for (int i = 0; i < 9; i++) rv[6*i +: 6] = 6'($urandom);
    obs_q.delete(); load_cyc_q.delete();
    ROWS = 6'd9;
    for (int i = 0; i < 4; i++) push_row(rv[6*i +: 6]);
    @(posedge clk); #1;
    clk_en = 1'b0;
    row_valid = 1'b1;
    row_data = 6'($urandom);
    stall_ready = 0;
    repeat (10) begin @(negedge clk); if (row_ready) stall_ready++; end
    checks++; if (stall_ready != 0) begin failures++; $display("FAIL stall_ready: ready cycles=%0d want 0", stall_ready); end
    @(posedge clk); #1;
    row_valid = 1'b0;
    clk_en = 1'b1;
    for (int i = 4; i < 9; i++) push_row(rv[6*i +: 6]);
    wait_loads(1, 40, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL stall_timeout: no load pulse, required one"); end
    else if (obs_q[0] !== model_words(rv, 9)) begin failures++;
      $display("FAIL stall_words: got %h want %h", obs_q[0], model_words(rv, 9)); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_flush_gen_done();
    logic [83:0] rv;
    int g, bad;
    bit ok;
    rv = 84'h0;
    for (int i = 0; i < 9; i++) rv[6*i +: 6] = 6'($urandom);
    obs_q.delete(); load_cyc_q.delete();
    ROWS = 6'd9;
    push_row(rv[5:0]);
    push_row(rv[11:6]);
    @(posedge clk); #1;
    gen_done = 1'b1;
    wait_loads(1, 40, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL flush_timeout: no load pulse, required one"); end
    else if (obs_q[0] !== model_words(rv, 2)) begin failures++;
      $display("FAIL flush_words: got %h want %h", obs_q[0], model_words(rv, 2)); end
    checks++; if (generation_done !== 1'b0) begin failures++; $display("FAIL flush_done_early: got %0b want 0", generation_done); end
    g = 0;
    while (!generation_done && g < 40) begin @(negedge clk); g++; end
    checks++; if (generation_done !== 1'b1) begin failures++; $display("FAIL flush_done_set: got %0b want 1", generation_done); end
    row_valid = 1'b1;
    bad = 0;
    repeat (10) begin @(negedge clk); if (load || row_ready || !generation_done) bad++; end
    row_valid = 1'b0;
    checks++; if (bad != 0) begin failures++; $display("FAIL flush_quiet: bad cycles=%0d want 0", bad); end
    checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL flush_load_count: got %0d want 1", obs_q.size()); end
  endtask

  task automatic test_reset_holdoff();
    logic [83:0] rv;
    logic [5:0] y;
    bit ok;
    gen_done = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++; if (generation_done !== 1'b0) begin failures++; $display("FAIL rst_gd_clear: got %0b want 0", generation_done); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    rv = 84'h0;
    for (int i = 0; i < 4; i++) rv[6*i +: 6] = 6'($urandom) | 6'd1;
    obs_q.delete(); load_cyc_q.delete();
    ROWS = 6'd4;
    for (int i = 0; i < 4; i++) push_row(rv[6*i +: 6]);
    ROWS = 6'd3;
    push_row(6'($urandom) | 6'd1);
    wait_loads(1, 40, ok);
    checks++; if (!ok || data_out_0 !== model_words(rv, 4) >> 0 & 96'hFFFF_FFFF) begin failures++;
      $display("FAIL rst_pre_data: got %h want %h", data_out_0, model_words(rv, 4) & 96'hFFFF_FFFF); end
    reset_n = 1'b0;
    #1;
    checks++; if (load !== 1'b0) begin failures++; $display("FAIL rst_load: got %0b want 0", load); end
    checks++; if ({data_out_2, data_out_1, data_out_0} !== 96'h0) begin failures++;
      $display("FAIL rst_data: got %h want 0", {data_out_2, data_out_1, data_out_0}); end
    checks++; if (generation_done !== 1'b0) begin failures++; $display("FAIL rst_gd: got %0b want 0", generation_done); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    y = 6'($urandom) | 6'd1;
    obs_q.delete(); load_cyc_q.delete();
    ROWS = 6'd1;
    push_row(y);
    wait_loads(1, 40, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rst_first_timeout: no load pulse, required one"); end
    else if (obs_q[0] !== model_words({78'h0, y}, 1)) begin failures++;
      $display("FAIL rst_first_slot: got %h want %h", obs_q[0], model_words({78'h0, y}, 1)); end
  endtask

  initial begin
    test_reset();
    test_packing();
    test_back_to_back();
    test_clk_en_stall();
    test_flush_gen_done();
    test_reset_holdoff();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
